wv_row_streamer: RTL

//  Read side of the Wv weight memory: on a start pulse, fetches num_rows rows of 128 int8 weights
//  (16 x 64-bit words per row) from the Wv memory and streams them downstream as valid/ready beats.

---
 rtl/wv_row_streamer_pkg.sv | 40 ++++
 rtl/wv_row_streamer_if.sv | 32 +++
 rtl/wv_row_streamer_beat_fifo.sv | 73 +++++++
 rtl/wv_row_streamer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/wv_row_streamer_pkg.sv
// Shared types and constants for the Wv weight-memory read streamer.
// A weight row is 128 int8 values packed as 16 x 64-bit words. Byte 7 of
// each word holds the lowest column index.
package wv_row_streamer_pkg;

  localparam int WV_WIDTH         = 64;
  localparam int WV_WORDS_PER_ROW = 16;
  localparam int WV_MAX_ROWS      = 128;
  localparam int WV_FIFO_DEPTH    = 4;

  // Counter widths derived from the row geometry.
  localparam int WV_WORD_IDX_W = $clog2(WV_WORDS_PER_ROW);
  localparam int WV_ROW_IDX_W  = $clog2(WV_MAX_ROWS);
  localparam int WV_NUM_ROWS_W = $clog2(WV_MAX_ROWS + 1);

  // One buffered output beat: weight word plus its position tags.
  typedef struct packed {
    logic [WV_WIDTH-1:0]     data;
    logic                    row_last;
    logic                    last;
    logic [WV_ROW_IDX_W-1:0] row_idx;
  } wv_beat_t;

  typedef enum logic [1:0] {
    WV_IDLE  = 2'd0,
    WV_FETCH = 2'd1,
    WV_DRAIN = 2'd2
  } wv_fetch_state_e;

  // Word address of (row, word) relative to the job base. Plain 32-bit
  // unsigned arithmetic; wrap-around is intentionally not detected.
  function automatic logic [31:0] wv_word_addr(
    input logic [31:0]              base,
    input logic [WV_ROW_IDX_W-1:0]  row,
    input logic [WV_WORD_IDX_W-1:0] word
  );
    return base + (32'(row) * 32'(WV_WORDS_PER_ROW)) + 32'(word);
  endfunction

endpackage

// File: rtl/wv_row_streamer_if.sv
// Bus bundle of the streamer: the read-only port towards the Wv memory and
// the valid/ready weight stream towards the V-projection MAC array.
// master = streamer side, slave = memory/consumer side.
interface wv_row_streamer_if;
  import wv_row_streamer_pkg::*;

  logic                    mem_write_en;
  logic [31:0]             mem_addr;
  logic [WV_WIDTH-1:0]     mem_data_out;

  logic                    w_valid;
  logic                    w_ready;
  logic [WV_WIDTH-1:0]     w_data;
  logic                    w_row_last;
  logic                    w_last;
  logic [WV_ROW_IDX_W-1:0] w_row_idx;

  modport master (
    output mem_write_en, mem_addr,
    input  mem_data_out,
    output w_valid, w_data, w_row_last, w_last, w_row_idx,
    input  w_ready
  );

  modport slave (
    input  mem_write_en, mem_addr,
    output mem_data_out,
    input  w_valid, w_data, w_row_last, w_last, w_row_idx,
    output w_ready
  );

endinterface

// File: rtl/wv_row_streamer_beat_fifo.sv
// Synchronous show-ahead FIFO of tagged weight beats. The head entry is
// visible on o_head whenever o_empty is low, so the consumer sees data
// without a read request. Push and pop in the same cycle are allowed.
// Storage is reset so the stream outputs read zero after reset.
module wv_beat_fifo
  import wv_row_streamer_pkg::*;
#(
  parameter int DEPTH = WV_FIFO_DEPTH
)
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  wv_beat_t                   i_beat,
  input  logic                       i_pop,
  output wv_beat_t                   o_head,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  wv_beat_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~w_full | w_pop);

  // Storage write; a push into a full FIFO is only taken alongside a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_beat;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/wv_row_streamer.sv
// Read side of the Wv weight memory. A start pulse launches a job of
// num_rows rows; every word is read from the memory (fixed 1-cycle read
// latency, no stall) and streamed out as valid/ready beats through a small
// show-ahead FIFO. Reads are only issued when the FIFO is guaranteed to
// have room for the returning word, since the memory cannot be stalled.
module wv_row_streamer
  import wv_row_streamer_pkg::*;
#(
  parameter int FIFO_DEPTH = WV_FIFO_DEPTH
)
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic [31:0]              i_base_addr,
  input  logic [WV_NUM_ROWS_W-1:0] i_num_rows,
  output logic                     o_busy,
  output logic                     o_done,
  wv_row_streamer_if.master        bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  wv_fetch_state_e r_state;
  wv_fetch_state_e w_next_state;

  logic [31:0]              r_base_addr;
  logic [WV_NUM_ROWS_W-1:0] r_num_rows;
  logic [WV_ROW_IDX_W-1:0]  r_row_cnt;
  logic [WV_WORD_IDX_W-1:0] r_word_cnt;
  logic [31:0]              r_mem_addr;
  logic                     r_rd_inflight;
  logic                     r_tag_row_last;
  logic                     r_tag_last;
  logic [WV_ROW_IDX_W-1:0]  r_tag_row_idx;
  logic                     r_done;

  logic                     w_start_job;
  logic                     w_start_empty;
  logic                     w_issue;
  logic                     w_word_last;
  logic                     w_job_last;
  logic                     w_pop;
  logic                     w_last_pop;
  logic                     w_fifo_empty;
  logic [CNT_W-1:0]         w_fifo_count;
  wv_beat_t                 w_push_beat;
  wv_beat_t                 w_head;

  // A start is only honoured in IDLE; a zero-row job just pulses done.
  assign w_start_job   = (r_state == WV_IDLE) && i_start && (i_num_rows != '0);
  assign w_start_empty = (r_state == WV_IDLE) && i_start && (i_num_rows == '0);

  // Count the outstanding read as occupied so its data always has a slot.
  assign w_issue = (r_state == WV_FETCH) &&
                   ((SUM_W'(w_fifo_count) + SUM_W'(r_rd_inflight)) < SUM_W'(FIFO_DEPTH));

  assign w_word_last = (r_word_cnt == WV_WORD_IDX_W'(WV_WORDS_PER_ROW - 1));
  assign w_job_last  = w_word_last &&
                       (WV_NUM_ROWS_W'(r_row_cnt) == (r_num_rows - WV_NUM_ROWS_W'(1)));

  assign w_pop      = ~w_fifo_empty & bus.w_ready;
  assign w_last_pop = w_pop & w_head.last;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WV_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: FETCH until the last word is issued, DRAIN until it is handed off.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WV_IDLE: begin
        if (w_start_job) begin
          w_next_state = WV_FETCH;
        end
      end
      WV_FETCH: begin
        if (w_issue && w_job_last) begin
          w_next_state = WV_DRAIN;
        end
      end
      WV_DRAIN: begin
        if (w_last_pop) begin
          w_next_state = WV_IDLE;
        end
      end
      default: w_next_state = WV_IDLE;
    endcase
  end

  // Latch the job parameters on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base_addr <= '0;
      r_num_rows  <= '0;
    end else if (w_start_job) begin
      r_base_addr <= i_base_addr;
      r_num_rows  <= i_num_rows;
    end
  end

  // Read issue: address, row/word counters and the tags travelling with the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_cnt      <= '0;
      r_word_cnt     <= '0;
      r_mem_addr     <= '0;
      r_rd_inflight  <= 1'b0;
      r_tag_row_last <= 1'b0;
      r_tag_last     <= 1'b0;
      r_tag_row_idx  <= '0;
    end else begin
      r_rd_inflight <= w_issue;
      if (w_start_job) begin
        r_row_cnt  <= '0;
        r_word_cnt <= '0;
      end else if (w_issue) begin
        r_mem_addr     <= wv_word_addr(r_base_addr, r_row_cnt, r_word_cnt);
        r_tag_row_last <= w_word_last;
        r_tag_last     <= w_job_last;
        r_tag_row_idx  <= r_row_cnt;
        if (w_word_last) begin
          r_word_cnt <= '0;
          r_row_cnt  <= r_row_cnt + WV_ROW_IDX_W'(1);
        end else begin
          r_word_cnt <= r_word_cnt + WV_WORD_IDX_W'(1);
        end
      end
    end
  end

  // Done pulses once, the cycle after an empty job or the final handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_start_empty | ((r_state == WV_DRAIN) & w_last_pop);
    end
  end

  // Join returning memory data with the tags issued one cycle earlier.
  always_comb begin
    w_push_beat          = '0;
    w_push_beat.data     = bus.mem_data_out;
    w_push_beat.row_last = r_tag_row_last;
    w_push_beat.last     = r_tag_last;
    w_push_beat.row_idx  = r_tag_row_idx;
  end

  wv_beat_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_rd_inflight),
    .i_beat  (w_push_beat),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign bus.mem_write_en = 1'b0;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.w_valid      = ~w_fifo_empty;
  assign bus.w_data       = w_head.data;
  assign bus.w_row_last   = w_head.row_last;
  assign bus.w_last       = w_head.last;
  assign bus.w_row_idx    = w_head.row_idx;

  assign o_busy = (r_state != WV_IDLE);
  assign o_done = r_done;

endmodule
